// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - Feeds row/weight beats into a 16x2 PE array and sequences the
// round/write-back strobe once a job of k_len beats has been accepted.
module pe_array_feeder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   k_len,
  input  logic [3:0]   acc_sel,
  input  logic [3:0]   rnd_sel,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_row,
  input  logic [31:0]  in_wgt,
  output logic [255:0] data_input_matrix,
  output logic [31:0]  data_weight_matrix,
  output logic         mac_en,
  output logic [3:0]   add_number,
  output logic [3:0]   rounder_number,
  output logic         rounder_en,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FEED   = 2'd1,
    S_ROUND  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [4:0]     r_beat_cnt;
  logic [4:0]     r_len;
  logic [3:0]     r_add_number;
  logic [3:0]     r_rounder_number;
  logic [255:0]   r_row;
  logic [31:0]    r_wgt;
  logic           r_mac_en;
  logic           r_rounder_en;
  logic           r_done;

  logic           w_accept;
  logic           w_in_ready;
  logic           w_hs;
  logic           w_last;
  logic           w_busy;
  logic [4:0]     w_cnt_inc;
  logic [4:0]     w_eff_len;

  // k_len of zero stands for a full 16-beat job.
  assign w_eff_len = (k_len == 4'd0) ? 5'd16 : {1'b0, k_len};
  assign w_cnt_inc = r_beat_cnt + 5'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b1;
    w_accept    = 1'b0;
    w_hs        = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy   = 1'b0;
        w_accept = start;
        if (start) w_state_nxt = S_FEED;
      end
      S_FEED: begin
        w_in_ready = 1'b1;
        w_hs       = in_valid;
        w_last     = in_valid && (w_cnt_inc == r_len);
        if (w_last) w_state_nxt = S_ROUND;
      end
      S_ROUND:  w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_beat_cnt       <= 5'd0;
      r_len            <= 5'd0;
      r_add_number     <= 4'd0;
      r_rounder_number <= 4'd0;
      r_row            <= 256'd0;
      r_wgt            <= 32'd0;
      r_mac_en         <= 1'b0;
      r_rounder_en     <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mac_en     <= w_hs;
      r_rounder_en <= (r_state == S_ROUND);
      r_done       <= (r_state == S_FINISH);
      // The selects are captured straight into the output registers so they are
      // already stable in the first busy cycle.
      if (w_accept) begin
        r_beat_cnt       <= 5'd0;
        r_len            <= w_eff_len;
        r_add_number     <= acc_sel;
        r_rounder_number <= rnd_sel;
      end else if (w_hs) begin
        r_beat_cnt <= w_cnt_inc;
      end
      if (w_hs) begin
        r_row <= in_row;
        r_wgt <= in_wgt;
      end
    end
  end

  assign in_ready           = w_in_ready;
  assign busy               = w_busy;
  assign data_input_matrix  = r_row;
  assign data_weight_matrix = r_wgt;
  assign mac_en             = r_mac_en;
  assign add_number         = r_add_number;
  assign rounder_number     = r_rounder_number;
  assign rounder_en         = r_rounder_en;
  assign done               = r_done;

endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - Scoreboard bench for pe_array_feeder.
module tb_pe_array_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   k_len = 4'd0;
  logic [3:0]   acc_sel = 4'd0;
  logic [3:0]   rnd_sel = 4'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_row = '0;
  logic [31:0]  in_wgt = '0;
  logic [255:0] data_input_matrix;
  logic [31:0]  data_weight_matrix;
  logic         mac_en;
  logic [3:0]   add_number;
  logic [3:0]   rounder_number;
  logic         rounder_en;
  logic         busy;
  logic         done;

  pe_array_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_sel(acc_sel),
    .rnd_sel(rnd_sel), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_wgt(in_wgt), .data_input_matrix(data_input_matrix),
    .data_weight_matrix(data_weight_matrix), .mac_en(mac_en), .add_number(add_number),
    .rounder_number(rounder_number), .rounder_en(rounder_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] row;
    logic [31:0]  wgt;
    logic [3:0]   acc;
    logic [3:0]   rnd;
    bit           last;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_rnd_cyc = -1;
  int exp_done_cyc = -1;
  logic [3:0] last_acc = 4'd0;
  logic [3:0] last_rnd = 4'd0;

  // reference job state: one job of m_len beats at a time, starts ignored while active
  bit         m_active = 1'b0;
  int         m_len = 0;
  int         m_cnt = 0;
  logic [3:0] m_acc = 4'd0;
  logic [3:0] m_rnd = 4'd0;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  logic [255:0] prev_row = '0;
  logic [31:0]  prev_wgt = '0;

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst_n) begin
      if (mac_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mac_en", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("row", data_input_matrix, b.row);
          chk("wgt", data_weight_matrix, b.wgt);
          chk("add_number", add_number, b.acc);
          chk("rounder_number", rounder_number, b.rnd);
          if (b.last) begin
            exp_rnd_cyc = cyc + 1;
            last_acc = b.acc;
            last_rnd = b.rnd;
          end
        end
      end else begin
        chk("row_hold", data_input_matrix, prev_row);
        chk("wgt_hold", data_weight_matrix, prev_wgt);
      end
      if (rounder_en || cyc == exp_rnd_cyc) begin
        chk("rounder_en_timing", (rounder_en && cyc == exp_rnd_cyc), 1);
        chk("round_add_number", add_number, last_acc);
        if (rounder_en) exp_done_cyc = cyc + 1;
        exp_rnd_cyc = -1;
      end else if (done || cyc == exp_done_cyc) begin
        chk("done_timing", (done && cyc == exp_done_cyc), 1);
        chk("done_busy", busy, 0);
        chk("done_rounder_number", rounder_number, last_rnd);
        exp_done_cyc = -1;
      end
    end
    prev_row = data_input_matrix;
    prev_wgt = data_weight_matrix;
  end

  task automatic do_start(input logic [3:0] k, input logic [3:0] a, input logic [3:0] r);
    start = 1'b1; k_len = k; acc_sel = a; rnd_sel = r;
    if (!m_active) begin
      m_active = 1'b1;
      m_len = (k == 4'd0) ? 16 : int'(k);
      m_cnt = 0;
      m_acc = a;
      m_rnd = r;
    end
    @(posedge clk); #1;
    start = 1'b0;
    k_len = 4'($urandom); acc_sel = 4'($urandom); rnd_sel = 4'($urandom);
  endtask

  task automatic send_beat(input int stalls);
    beat_t b;
    bit ok;
    in_valid = 1'b0;
    repeat (stalls) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) in_row[32*i +: 32] = $urandom;
    in_wgt = $urandom;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        m_cnt++;
        b.row = in_row; b.wgt = in_wgt; b.acc = m_acc; b.rnd = m_rnd;
        b.last = (m_cnt == m_len);
        if (b.last) m_active = 1'b0;
        exp_q.push_back(b);
        chk("busy_in_feed", busy, 1);
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b0;
    in_row = {8{$urandom}};
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_job(input logic [3:0] k, input logic [3:0] a, input logic [3:0] r,
                         input int max_stall);
    int n;
    n = (k == 4'd0) ? 16 : int'(k);
    do_start(k, a, r);
    for (int i = 0; i < n; i++) send_beat($urandom_range(0, max_stall));
    wait_done();
  endtask

  initial begin
    int s4[4];
    #1;
    chk("reset_outputs", {data_input_matrix, data_weight_matrix, mac_en, add_number,
        rounder_number, rounder_en, busy, done, in_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);

    // k=3 back-to-back
    run_job(4'd3, 4'd5, 4'd2, 0);

    // k=0 means 16 beats; in_ready drops after the last one
    do_start(4'd0, 4'd7, 4'd11);
    for (int i = 0; i < 16; i++) send_beat(0);
    chk("in_ready_after_16", in_ready, 0);
    wait_done();

    // k=4 with in_valid 1,0,0,1,1,0,1
    s4 = '{0, 2, 0, 1};
    do_start(4'd4, 4'd3, 4'd9);
    for (int i = 0; i < 4; i++) send_beat(s4[i]);
    wait_done();

    // start during FEED is ignored
    do_start(4'd2, 4'd9, 4'd3);
    send_beat(0);
    do_start(4'd7, 4'd1, 4'd6);
    send_beat(1);
    wait_done();
    @(posedge clk); #1;
    chk("no_job_after_ignored_start", busy, 0);

    // reset after 2nd of 5 beats
    do_start(4'd5, 4'd12, 4'd4);
    send_beat(0);
    send_beat(0);
    rst_n = 1'b0;
    #1;
    chk("midjob_reset_outputs", {data_input_matrix, data_weight_matrix, mac_en, add_number,
        rounder_number, rounder_en, busy, done, in_ready}, 0);
    exp_q.delete();
    exp_rnd_cyc = -1;
    exp_done_cyc = -1;
    m_active = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", busy, 0);
    run_job(4'd1, 4'd10, 4'd13, 1);

    // start in the done cycle
    run_job(4'd2, 4'd6, 4'd8, 0);
    do_start(4'd3, 4'd14, 4'd1);
    chk("busy_after_done_start", busy, 1);
    for (int i = 0; i < 3; i++) send_beat(0);
    wait_done();

    for (int j = 0; j < 6; j++)
      run_job(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 2);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
